// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx -- oversampling UART receiver (8N1, optionally 8E1)
//
// Receive-side counterpart of uart_tx, sharing its baud parameters. The serial
// line is synchronized, start bits are found on a falling edge, and each bit
// is decided by a 2-of-3 majority vote around the bit centre. Received bytes
// are offered on a single-entry data/valid/require handshake.
//
// Parameters
//   CLK_FREQ    system clock frequency in Hz
//   UART_BPS    baud rate; DIV = CLK_FREQ/UART_BPS, HALF = DIV/2
//
// Ports
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   uart_rxd    serial line, idle high, asynchronous to clk
//   data[7:0]   received byte, stable while valid = 1
//   valid       data holds an unconsumed byte
//   require     consumer accepts data in any cycle with valid = 1
//   frame_err   one-cycle pulse: stop bit sampled as 0
//   overrun     one-cycle pulse: good byte dropped, holding register full
//   parity_err  one-cycle pulse: even-parity mismatch (0 when compiled out)
//
// Build option
//   UART_RX_PARITY_EN  when defined, an even-parity bit is expected between
//                      the data bits and the stop bit.
// -----------------------------------------------------------------------------
module uart_rx #(
   parameter int CLK_FREQ = 50_000_000,
   parameter int UART_BPS = 115200
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       uart_rxd,
   output logic [7:0] data,
   output logic       valid,
   input  logic       require,
   output logic       frame_err,
   output logic       overrun,
   output logic       parity_err
);

   localparam int DIV  = CLK_FREQ / UART_BPS;
   localparam int HALF = DIV / 2;
   localparam int TW   = (DIV > 2) ? $clog2(DIV) : 2;

   localparam logic [TW-1:0] CNT_LAST   = TW'(DIV - 1);
   localparam logic [TW-1:0] CNT_SAMP0  = TW'(HALF - 1);
   localparam logic [TW-1:0] CNT_SAMP1  = TW'(HALF);
   localparam logic [TW-1:0] CNT_DECIDE = TW'(HALF + 1);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_START     = 3'd1,
      ST_DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
      ST_PARITY    = 3'd3,
`endif
      ST_STOP      = 3'd4,
      ST_WAIT_HIGH = 3'd5
   } state_t;

   // 2-of-3 majority of the three samples taken around the bit centre
   function automatic logic majority3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

   // Even-parity bit for a byte: the value that makes the total count of ones even
   function automatic logic even_parity8(input logic [7:0] d);
      return ^d;
   endfunction

   // ---------------------------------------------------------------- state
   logic          sync1_r, sync2_r, rxd_d_r;
   state_t        state_r, state_s;
   logic [TW-1:0] timer_r, timer_s;
   logic          samp0_r, samp0_s;
   logic          samp1_r, samp1_s;
   logic [7:0]    shift_r, shift_s;
   logic [2:0]    bitcnt_r, bitcnt_s;
`ifdef UART_RX_PARITY_EN
   logic          par_bad_r, par_bad_s;
   logic          perr_s;
`endif

   // ---------------------------------------------------------------- comb
   logic          vote_s;
   logic          decide_s;
   logic          deliver_s;
   logic          ferr_s;
   logic          load_s;
   logic          ovr_s;
   logic [7:0]    data_s;
   logic          valid_s;

   // Two-flop synchronizer plus edge register. All three reset to 0 so that a
   // line held low across reset release never produces a falling edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_r <= 1'b0;
         sync2_r <= 1'b0;
         rxd_d_r <= 1'b0;
      end else begin
         sync1_r <= uart_rxd;
         sync2_r <= sync1_r;
         rxd_d_r <= sync2_r;
      end
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state and datapath decode. The timer holds 0 in IDLE, so the cycle
   // that sees the start edge counts as 0 and every later decision lands at
   // count HALF+1 of its bit period.
   always_comb begin
      state_s   = state_r;
      timer_s   = (timer_r == CNT_LAST) ? {TW{1'b0}} : (timer_r + TW'(1));
      shift_s   = shift_r;
      bitcnt_s  = bitcnt_r;
      deliver_s = 1'b0;
      ferr_s    = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_s = par_bad_r;
      perr_s    = 1'b0;
`endif
      samp0_s   = (timer_r == CNT_SAMP0) ? sync2_r : samp0_r;
      samp1_s   = (timer_r == CNT_SAMP1) ? sync2_r : samp1_r;
      decide_s  = (timer_r == CNT_DECIDE);
      vote_s    = majority3(samp0_r, samp1_r, sync2_r);

      case (state_r)
         ST_IDLE: begin
            timer_s = {TW{1'b0}};
            if (rxd_d_r && !sync2_r) begin
               state_s = ST_START;
               timer_s = TW'(1);
            end else begin
               state_s = ST_IDLE;
            end
         end

         ST_START: begin
            if (decide_s) begin
               if (!vote_s) begin
                  state_s  = ST_DATA;
                  bitcnt_s = 3'd0;
               end else begin
                  // false start: glitch shorter than half a bit
                  state_s = ST_IDLE;
                  timer_s = {TW{1'b0}};
               end
            end else begin
               state_s = ST_START;
            end
         end

         ST_DATA: begin
            if (decide_s) begin
               // LSB arrives first, so shift in from the top
               shift_s  = {vote_s, shift_r[7:1]};
               bitcnt_s = bitcnt_r + 3'd1;
               if (bitcnt_r == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                  state_s = ST_PARITY;
`else
                  state_s = ST_STOP;
`endif
               end else begin
                  state_s = ST_DATA;
               end
            end else begin
               state_s = ST_DATA;
            end
         end

`ifdef UART_RX_PARITY_EN
         ST_PARITY: begin
            if (decide_s) begin
               par_bad_s = vote_s ^ even_parity8(shift_r);
               state_s   = ST_STOP;
            end else begin
               state_s = ST_PARITY;
            end
         end
`endif

         ST_STOP: begin
            if (decide_s) begin
               if (!vote_s) begin
                  ferr_s  = 1'b1;
                  state_s = ST_WAIT_HIGH;
`ifdef UART_RX_PARITY_EN
               end else if (par_bad_r) begin
                  perr_s  = 1'b1;
                  state_s = ST_IDLE;
                  timer_s = {TW{1'b0}};
`endif
               end else begin
                  // back to IDLE at the decision so a start edge arriving
                  // within the second half of the stop bit is still seen
                  deliver_s = 1'b1;
                  state_s   = ST_IDLE;
                  timer_s   = {TW{1'b0}};
               end
            end else begin
               state_s = ST_STOP;
            end
         end

         ST_WAIT_HIGH: begin
            timer_s = {TW{1'b0}};
            if (sync2_r) begin
               state_s = ST_IDLE;
            end else begin
               state_s = ST_WAIT_HIGH;
            end
         end

         default: begin
            state_s = ST_IDLE;
            timer_s = {TW{1'b0}};
         end
      endcase
   end

   // Holding-register handshake: load when empty or being drained this cycle,
   // otherwise keep the old byte and report the drop.
   always_comb begin
      load_s  = deliver_s && (!valid || require);
      ovr_s   = deliver_s && valid && !require;
      data_s  = data;
      valid_s = valid;
      if (load_s) begin
         data_s  = shift_r;
         valid_s = 1'b1;
      end else if (valid && require) begin
         valid_s = 1'b0;
      end else begin
         valid_s = valid;
      end
   end

   // Receive datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         timer_r   <= {TW{1'b0}};
         samp0_r   <= 1'b1;
         samp1_r   <= 1'b1;
         shift_r   <= 8'h00;
         bitcnt_r  <= 3'd0;
`ifdef UART_RX_PARITY_EN
         par_bad_r <= 1'b0;
`endif
      end else begin
         timer_r   <= timer_s;
         samp0_r   <= samp0_s;
         samp1_r   <= samp1_s;
         shift_r   <= shift_s;
         bitcnt_r  <= bitcnt_s;
`ifdef UART_RX_PARITY_EN
         par_bad_r <= par_bad_s;
`endif
      end
   end

   // Registered outputs: holding register, valid flag and one-cycle fault pulses
   always_ff @(posedge clk) begin
      if (rst) begin
         data      <= 8'h00;
         valid     <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         data      <= data_s;
         valid     <= valid_s;
         frame_err <= ferr_s;
         overrun   <= ovr_s;
      end
   end

`ifdef UART_RX_PARITY_EN
   // Parity fault pulse
   always_ff @(posedge clk) begin
      if (rst) begin
         parity_err <= 1'b0;
      end else begin
         parity_err <= perr_s;
      end
   end
`else
   assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx -- self-checking bench for uart_rx.
// Frames are built bit by bit from the byte value; expected bytes, flag counts
// and arrival cycles come from the frame timing rules (pin edge + 2 sync
// cycles + decision point + 1 register stage).
// -----------------------------------------------------------------------------
module tb_uart_rx;

   localparam int CLK_FREQ = 50_000_000;
   localparam int UART_BPS = 115200;
   localparam int DIV      = CLK_FREQ / UART_BPS;
   localparam int HALF     = DIV / 2;
`ifdef UART_RX_PARITY_EN
   localparam int NBITS    = 10;   // start + 8 data + parity before stop
`else
   localparam int NBITS    = 9;    // start + 8 data before stop
`endif
   // pin falling edge -> cycle in which valid (or an error flag) is high
   localparam int LAT      = 2 + NBITS * DIV + HALF + 2;

   logic       clk = 1'b0;
   logic       rst;
   logic       uart_rxd;
   logic [7:0] data;
   logic       valid;
   logic       require;
   logic       frame_err;
   logic       overrun;
   logic       parity_err;

   int tests = 0;
   int fails = 0;

   uart_rx #(.CLK_FREQ(CLK_FREQ), .UART_BPS(UART_BPS)) dut (
      .clk        (clk),
      .rst        (rst),
      .uart_rxd   (uart_rxd),
      .data       (data),
      .valid      (valid),
      .require    (require),
      .frame_err  (frame_err),
      .overrun    (overrun),
      .parity_err (parity_err)
   );

   always #5 clk = ~clk;

   // ------------------------------------------------------------ monitor
   int unsigned cyc        = 0;
   int unsigned vrise_cyc  = 0;
   logic [7:0]  vrise_data = 8'h00;
   logic        valid_q    = 1'b0;
   int unsigned vhigh_cnt  = 0;
   int unsigned ferr_cnt   = 0;
   int unsigned ferr_cyc   = 0;
   int unsigned ovr_cnt    = 0;
   int unsigned ovr_cyc    = 0;
   int unsigned perr_cnt   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (valid && !valid_q) begin
         vrise_cyc  <= cyc;
         vrise_data <= data;
      end
      valid_q <= valid;
      if (valid)      vhigh_cnt <= vhigh_cnt + 1;
      if (frame_err)  begin ferr_cnt <= ferr_cnt + 1; ferr_cyc <= cyc; end
      if (overrun)    begin ovr_cnt  <= ovr_cnt + 1;  ovr_cyc  <= cyc; end
      if (parity_err) perr_cnt <= perr_cnt + 1;
   end

   // ------------------------------------------------------------ helpers
   int unsigned last_start;
   int unsigned v0, f0, o0, p0;
`ifdef UART_RX_PARITY_EN
   logic par_corrupt = 1'b0;
`endif

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // even parity of a byte, counted as plain arithmetic
   function automatic logic ref_parity(input logic [7:0] b);
      int ones = 0;
      for (int i = 0; i < 8; i++) ones += (b >> i) & 1;
      return logic'(ones % 2);
   endfunction

   task automatic snap();
      v0 = vhigh_cnt; f0 = ferr_cnt; o0 = ovr_cnt; p0 = perr_cnt;
   endtask

   task automatic idle(input int n);
      uart_rxd = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   // drive one full frame; must be called right after a negedge
   task automatic send_frame(input logic [7:0] b, input logic stop_bit);
      last_start = cyc;
      uart_rxd = 1'b0;
      repeat (DIV) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         uart_rxd = b[i];
         repeat (DIV) @(negedge clk);
      end
`ifdef UART_RX_PARITY_EN
      uart_rxd = ref_parity(b) ^ par_corrupt;
      repeat (DIV) @(negedge clk);
`endif
      uart_rxd = stop_bit;
      repeat (DIV) @(negedge clk);
   endtask

   task automatic expect_byte(input string tag, input logic [7:0] b);
      check({tag, "_data"}, {24'h0, vrise_data}, {24'h0, b});
      check({tag, "_time"}, vrise_cyc, last_start + LAT);
      check({tag, "_vcnt"}, vhigh_cnt - v0, 32'd1);
      check({tag, "_flags"}, (ferr_cnt - f0) + (ovr_cnt - o0) + (perr_cnt - p0), 32'd0);
   endtask

   // ------------------------------------------------------------ stimulus
   initial begin
      logic [7:0] rb;
      int         gap;

      // reset with the line low: no false start after release
      rst = 1'b1; uart_rxd = 1'b0; require = 1'b0;
      repeat (4) @(negedge clk);
      check("rst_data", {24'h0, data}, 32'h0);
      check("rst_valid", {31'h0, valid}, 32'h0);
      check("rst_ferr", {31'h0, frame_err}, 32'h0);
      check("rst_ovr", {31'h0, overrun}, 32'h0);
      check("rst_perr", {31'h0, parity_err}, 32'h0);
      snap();
      rst = 1'b0;
      repeat (10 * DIV) @(negedge clk);
      check("lowrel_vcnt", vhigh_cnt - v0, 32'd0);
      check("lowrel_ferr", ferr_cnt - f0, 32'd0);
      idle(2 * DIV);

      // 0x55 with require held high
      require = 1'b1;
      snap();
      send_frame(8'h55, 1'b1);
      expect_byte("rx55", 8'h55);
      idle(DIV);

      // 100-cycle glitch, then 0xC3
      snap();
      uart_rxd = 1'b0;
      repeat (100) @(negedge clk);
      idle(2 * DIV);
      check("glitch_vcnt", vhigh_cnt - v0, 32'd0);
      check("glitch_flags", (ferr_cnt - f0) + (ovr_cnt - o0) + (perr_cnt - p0), 32'd0);
      snap();
      send_frame(8'hC3, 1'b1);
      expect_byte("rxC3", 8'hC3);
      idle(DIV);

      // stop bit forced low, line held low (break), then 0x3C
      snap();
      send_frame(8'hA3, 1'b0);
      uart_rxd = 1'b0;
      repeat (2000) @(negedge clk);
      check("ferr_cnt", ferr_cnt - f0, 32'd1);
      check("ferr_time", ferr_cyc, last_start + LAT);
      check("ferr_vcnt", vhigh_cnt - v0, 32'd0);
      idle(DIV);
      snap();
      send_frame(8'h3C, 1'b1);
      expect_byte("rx3C", 8'h3C);
      idle(DIV);

      // reset for one cycle in the middle of data bit 4 of 0x9A
      snap();
      rb = 8'h9A;
      uart_rxd = 1'b0;
      repeat (DIV) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         uart_rxd = rb[i];
         repeat (DIV) @(negedge clk);
      end
      uart_rxd = rb[4];
      repeat (HALF) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("mid_rst_valid", {31'h0, valid}, 32'h0);
      check("mid_rst_data", {24'h0, data}, 32'h0);
      idle(12 * DIV);
      check("mid_rst_vcnt", vhigh_cnt - v0, 32'd0);
      check("mid_rst_flags", (ferr_cnt - f0) + (ovr_cnt - o0) + (perr_cnt - p0), 32'd0);
      snap();
      send_frame(8'h5A, 1'b1);
      expect_byte("rx5A", 8'h5A);
      idle(DIV);

      // back-to-back 0x00, 0xFF with nobody consuming
      require = 1'b0;
      snap();
      send_frame(8'h00, 1'b1);
      check("b2b_first", {24'h0, vrise_data}, 32'h0);
      send_frame(8'hFF, 1'b1);
      check("b2b_data", {24'h0, data}, 32'h0);
      check("b2b_valid", {31'h0, valid}, 32'h1);
      check("b2b_ovr_cnt", ovr_cnt - o0, 32'd1);
      check("b2b_ovr_time", ovr_cyc, last_start + LAT);
      require = 1'b1;
      @(negedge clk);
      check("b2b_drain", {31'h0, valid}, 32'h0);
      idle(DIV);

      // random bytes with random inter-frame gaps (0 = back-to-back)
      for (int n = 0; n < 4; n++) begin
         rb  = 8'($urandom_range(0, 255));
         gap = $urandom_range(0, DIV);
         snap();
         send_frame(rb, 1'b1);
         expect_byte("rand", rb);
         idle(gap);
      end

`ifdef UART_RX_PARITY_EN
      // good and bad parity on 0x07
      idle(DIV);
      snap();
      send_frame(8'h07, 1'b1);
      expect_byte("par_ok", 8'h07);
      idle(DIV);
      snap();
      par_corrupt = 1'b1;
      send_frame(8'h07, 1'b1);
      par_corrupt = 1'b0;
      idle(DIV);
      check("par_bad_perr", perr_cnt - p0, 32'd1);
      check("par_bad_vcnt", vhigh_cnt - v0, 32'd0);
`else
      check("perr_never", perr_cnt, 32'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
